qarma_shuffle_engine: RTL



---
 rtl/qarma_shuffle_engine.sv | 125 ++++++++++++
 1 files changed

// File: rtl/qarma_shuffle_engine.sv
// Sequential QARMA cell-shuffle engine: applies tau, tau^-1, h or h^-1 to a
// 64/128-bit block a programmable number of times, one application per clock.
module qarma_shuffle_engine #(
  parameter int unsigned N     = 128,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       in_mode,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             busy
);

  localparam int unsigned M = N / 16;

  // Source-cell tables, one nibble per destination cell, cell 0 first.
  localparam logic [63:0] TBL_TAU     = 64'h0b6da1c75e38f492;
  localparam logic [63:0] TBL_TAU_INV = 64'h05fad827be41639c;
  localparam logic [63:0] TBL_H       = 64'h65ef01237cd489ab;
  localparam logic [63:0] TBL_H_INV   = 64'h4567b108cdef9a23;

  if (N != 64 && N != 128) begin : g_bad_width
    $error("qarma_shuffle_engine: N must be 64 or 128");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     data_q, data_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [CNT_W-1:0] rem_q, rem_nxt;
  logic             valid_q, valid_nxt;
  logic             ready_q, ready_nxt;
  logic             busy_q, busy_nxt;

  // One application of the selected permutation: out cell i = in cell P[i].
  function automatic logic [N-1:0] permute(input logic [N-1:0] d, input logic [1:0] mode);
    logic [63:0]  tbl;
    logic [N-1:0] r;
    int unsigned  src;
    case (mode)
      2'd0:    tbl = TBL_TAU;
      2'd1:    tbl = TBL_TAU_INV;
      2'd2:    tbl = TBL_H;
      default: tbl = TBL_H_INV;
    endcase
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      src = 32'(tbl[63-4*i -: 4]);
      r[N-1-M*i -: M] = d[N-1-M*src -: M];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      data_q  <= data_nxt;
      mode_q  <= mode_nxt;
      rem_q   <= rem_nxt;
      valid_q <= valid_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // out_valid rises one cycle after DONE is entered and drops on consumption.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    mode_nxt  = mode_q;
    rem_nxt   = rem_q;
    valid_nxt = valid_q;
    case (state)
      IDLE: begin
        if (in_valid && ready_q) begin
          data_nxt  = in_data;
          mode_nxt  = in_mode;
          rem_nxt   = in_count;
          state_nxt = (in_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        data_nxt = permute(data_q, mode_q);
        rem_nxt  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (!valid_q) begin
          valid_nxt = 1'b1;
        end else if (out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = (state_nxt != IDLE);
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

endmodule
